// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA sync/pixel timing with a lock-gated run FSM and one registered DAC stage; define VGA_TEST_PATTERN_EN for built-in colour bars.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        refclk,
  input  logic        rst,
  input  logic        locked,
  input  logic [23:0] pixel_rgb,
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic        video_on,
  output logic        frame_start,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk
);
  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  typedef enum logic {WAIT_LOCK, RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  hcount_q, hcount_d, vcount_q, vcount_d;
  logic        video_on_q, video_on_d, frame_start_q, frame_start_d;
  logic [23:0] rgb_q, rgb_d, src_rgb;
  logic        hs_q, hs_d, vs_q, vs_d, blank_n_q, blank_n_d;
  logic        run, h_wrap, advance;

`ifdef VGA_TEST_PATTERN_EN
  localparam logic [9:0] BAR_W = 10'(H_VISIBLE / 8);
  logic [2:0] bar;
  assign bar     = 3'(hcount_q / BAR_W);
  assign src_rgb = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
`else
  assign src_rgb = pixel_rgb;
`endif

  // Next-state for the counters/FSM and the stage-1 decode of the current stage-0 position
  always_comb begin
    run           = state_q == RUN;
    h_wrap        = hcount_q == H_LAST;
    advance       = run && locked;
    state_d       = locked ? RUN : WAIT_LOCK;
    hcount_d      = (advance && !h_wrap) ? hcount_q + 10'd1 : 10'd0;
    vcount_d      = !advance ? 10'd0 : !h_wrap ? vcount_q : (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    video_on_d    = locked && hcount_d < H_VIS && vcount_d < V_VIS;
    frame_start_d = locked && hcount_d == 10'd0 && vcount_d == 10'd0;
    hs_d          = !(run && hcount_q >= HS_FIRST && hcount_q <= HS_LAST);
    vs_d          = !(run && vcount_q >= VS_FIRST && vcount_q <= VS_LAST);
    blank_n_d     = run && video_on_q;
    rgb_d         = video_on_q ? src_rgb : 24'd0;
  end

  // Stage 0: run FSM with its registered position, visibility and frame-start outputs
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q       <= WAIT_LOCK;
      hcount_q      <= 10'd0;
      vcount_q      <= 10'd0;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      video_on_q    <= video_on_d;
      frame_start_q <= frame_start_d;
    end
  end

  // Stage 1: DAC colour, syncs and blanking, all one cycle behind stage 0
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      rgb_q     <= 24'd0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      rgb_q     <= rgb_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_n_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = refclk;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen with default horizontal and shortened vertical timing.
module tb_vga_timing_gen;
  localparam int HV = 640, HF = 16, HS = 96, HB = 48, HT = HV + HF + HS + HB;
  localparam int VV = 20, VF = 3, VS = 2, VB = 5, VT = VV + VF + VS + VB;

  logic        refclk = 1'b0, rst = 1'b1, locked = 1'b0;
  logic [23:0] pixel_rgb = 24'd0;
  logic [9:0]  hcount, vcount;
  logic        video_on, frame_start, vga_hs, vga_vs, vga_blank_n, vga_sync_n, vga_clk;
  logic [7:0]  vga_r, vga_g, vga_b;

  typedef struct packed {logic [23:0] rgb; logic hs; logic vs; logic bn;} s1_t;
  s1_t sb[$];
  int  m_h, m_v, n_cmp, n_err;
  bit  m_run, m_vo, m_fs;

  vga_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .refclk(refclk), .rst(rst), .locked(locked), .pixel_rgb(pixel_rgb),
    .hcount(hcount), .vcount(vcount), .video_on(video_on), .frame_start(frame_start),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .vga_hs(vga_hs), .vga_vs(vga_vs),
    .vga_blank_n(vga_blank_n), .vga_sync_n(vga_sync_n), .vga_clk(vga_clk)
  );

  always #5 refclk = ~refclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    m_h = 0; m_v = 0; m_run = 0; m_vo = 0; m_fs = 0;
    sb.delete();
  endtask

  // Drive one cycle, push the expected stage-1 result, advance the reference position.
  task automatic tick(input logic lk, input logic [23:0] px);
    s1_t e;
`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    bar = 3'(m_h / (HV / 8));
`endif
    locked = lk;
    pixel_rgb = px;
    e.hs = !(m_run && m_h >= HV + HF && m_h < HV + HF + HS);
    e.vs = !(m_run && m_v >= VV + VF && m_v < VV + VF + VS);
    e.bn = m_run && m_vo;
`ifdef VGA_TEST_PATTERN_EN
    e.rgb = m_vo ? {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}} : 24'd0;
`else
    e.rgb = m_vo ? px : 24'd0;
`endif
    sb.push_back(e);
    if (m_run && lk) begin
      m_h = (m_h == HT - 1) ? 0 : m_h + 1;
      if (m_h == 0) m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h = 0;
      m_v = 0;
    end
    m_run = lk;
    m_vo  = lk && m_h < HV && m_v < VV;
    m_fs  = lk && m_h == 0 && m_v == 0;
    @(posedge refclk);
    #1;
  endtask

  task automatic test_reset();
    s1_t e;
    model_reset();
    rst = 1'b1;
    locked = 1'b0;
    repeat (2) @(posedge refclk);
    #1;
    n_cmp++;
    if ({hcount, vcount, video_on, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n, vga_sync_n}
        !== {10'd0, 10'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got h=%0d v=%0d vo=%b fs=%b rgb=%h hs=%b vs=%b bn=%b sn=%b want all idle",
               hcount, vcount, video_on, frame_start, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n, vga_sync_n);
    end
    n_cmp++;
    if (vga_clk !== refclk) begin n_err++; $display("FAIL vga_clk_high: got %b want %b", vga_clk, refclk); end
    #5;
    n_cmp++;
    if (vga_clk !== refclk) begin n_err++; $display("FAIL vga_clk_low: got %b want %b", vga_clk, refclk); end
    #2 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick(1'b0, 24'($urandom));
      n_cmp++;
      if ({hcount, vcount, video_on, frame_start} !== {10'(m_h), 10'(m_v), m_vo, m_fs}) begin
        n_err++;
        $display("FAIL wait_lock_s0: got h=%0d v=%0d vo=%b fs=%b want h=%0d v=%0d vo=%b fs=%b",
                 hcount, vcount, video_on, frame_start, m_h, m_v, m_vo, m_fs);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL wait_lock_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
    end
  endtask

  task automatic test_lock_start();
    s1_t e;
    tick(1'b1, 24'($urandom));
    n_cmp++;
    if ({frame_start, hcount, vcount} !== {1'b1, 10'd0, 10'd0}) begin
      n_err++;
      $display("FAIL first_frame_start: got fs=%b h=%0d v=%0d want fs=1 h=0 v=0", frame_start, hcount, vcount);
    end
    e = sb.pop_front();
    n_cmp++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
      n_err++;
      $display("FAIL lock_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
    end
  endtask

  task automatic test_frame();
    s1_t e;
    int  fs_gap = -1, vs_low = 0;
    bit  wrap_ok = 0;
    logic [9:0] ph, pv;
    for (int k = 1; k <= HT * VT; k++) begin
      ph = hcount;
      pv = vcount;
      tick(1'b1, 24'($urandom));
      n_cmp++;
      if ({hcount, vcount, video_on, frame_start} !== {10'(m_h), 10'(m_v), m_vo, m_fs}) begin
        n_err++;
        $display("FAIL frame_s0: got h=%0d v=%0d vo=%b fs=%b want h=%0d v=%0d vo=%b fs=%b",
                 hcount, vcount, video_on, frame_start, m_h, m_v, m_vo, m_fs);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL frame_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
      if (!vga_vs) vs_low++;
      if (frame_start === 1'b1 && fs_gap < 0) fs_gap = k;
      if (pv == 10'(VT - 1) && ph == 10'(HT - 1)) wrap_ok = (vcount === 10'd0 && hcount === 10'd0);
    end
    n_cmp++;
    if (fs_gap != HT * VT) begin n_err++; $display("FAIL frame_period: got %0d want %0d", fs_gap, HT * VT); end
    n_cmp++;
    if (vs_low != VS * HT) begin n_err++; $display("FAIL vsync_width: got %0d want %0d", vs_low, VS * HT); end
    n_cmp++;
    if (!wrap_ok) begin n_err++; $display("FAIL frame_wrap: got vcount/hcount wrap %b want 1", wrap_ok); end
  endtask

  task automatic test_hsync();
    s1_t e;
    int  first = -1, cnt = 0;
    n_cmp++;
    if (hcount !== 10'd0) begin n_err++; $display("FAIL hsync_align: got h=%0d want 0", hcount); end
    for (int k = 1; k <= HT + 1; k++) begin
      tick(1'b1, 24'($urandom));
      n_cmp++;
      if ({hcount, vcount, video_on, frame_start} !== {10'(m_h), 10'(m_v), m_vo, m_fs}) begin
        n_err++;
        $display("FAIL hsync_s0: got h=%0d v=%0d vo=%b fs=%b want h=%0d v=%0d vo=%b fs=%b",
                 hcount, vcount, video_on, frame_start, m_h, m_v, m_vo, m_fs);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL hsync_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
      if (!vga_hs) begin
        if (first < 0) first = k;
        cnt++;
      end
    end
    n_cmp++;
    if (first != HV + HF + 1) begin n_err++; $display("FAIL hsync_start: got %0d want %0d", first, HV + HF + 1); end
    n_cmp++;
    if (cnt != HS) begin n_err++; $display("FAIL hsync_width: got %0d want %0d", cnt, HS); end
  endtask

  task automatic test_rgb();
    s1_t e;
    logic [9:0] ph;
    for (int k = 0; k < HT && m_h != 0; k++) begin
      tick(1'b1, 24'($urandom));
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL rgb_align_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
    end
    for (int k = 0; k < HT; k++) begin
      ph = hcount;
      tick(1'b1, 24'h123456);
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL rgb_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
`ifndef VGA_TEST_PATTERN_EN
      n_cmp++;
      if ({vga_blank_n, vga_r, vga_g, vga_b} !== ((ph < 10'(HV)) ? {1'b1, 24'h123456} : 25'd0)) begin
        n_err++;
        $display("FAIL rgb_passthrough: at h=%0d got bn=%b rgb=%h", ph, vga_blank_n, {vga_r, vga_g, vga_b});
      end
`endif
    end
  endtask

  task automatic test_unlock();
    s1_t e;
    int  k = 0;
    while (!(m_h == 300 && m_v == 10) && k < 2 * HT * VT) begin
      tick(1'b1, 24'($urandom));
      k++;
      n_cmp++;
      if ({hcount, vcount, video_on, frame_start} !== {10'(m_h), 10'(m_v), m_vo, m_fs}) begin
        n_err++;
        $display("FAIL unlock_run_s0: got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, m_h, m_v);
      end
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL unlock_run_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
    end
    n_cmp++;
    if (hcount !== 10'd300 || vcount !== 10'd10) begin
      n_err++;
      $display("FAIL unlock_reach: got h=%0d v=%0d want h=300 v=10", hcount, vcount);
    end
    tick(1'b0, 24'($urandom));
    void'(sb.pop_front());
    n_cmp++;
    if ({hcount, vcount, video_on, frame_start} !== 22'd0) begin
      n_err++;
      $display("FAIL unlock_s0_idle: got h=%0d v=%0d vo=%b fs=%b want 0 0 0 0", hcount, vcount, video_on, frame_start);
    end
    tick(1'b0, 24'($urandom));
    void'(sb.pop_front());
    n_cmp++;
    if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== {24'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL unlock_s1_idle: got rgb=%h hs=%b vs=%b bn=%b want 0 1 1 0",
               {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n);
    end
    repeat (3) begin
      tick(1'b0, 24'($urandom));
      void'(sb.pop_front());
      n_cmp++;
      if (hcount !== 10'd0 || frame_start !== 1'b0) begin
        n_err++;
        $display("FAIL unlock_hold: got h=%0d fs=%b want 0 0", hcount, frame_start);
      end
    end
    tick(1'b1, 24'($urandom));
    void'(sb.pop_front());
    n_cmp++;
    if ({frame_start, hcount, vcount} !== {1'b1, 10'd0, 10'd0}) begin
      n_err++;
      $display("FAIL relock_start: got fs=%b h=%0d v=%0d want 1 0 0", frame_start, hcount, vcount);
    end
    tick(1'b1, 24'($urandom));
    void'(sb.pop_front());
    n_cmp++;
    if (hcount !== 10'd1 || vcount !== 10'd0) begin
      n_err++;
      $display("FAIL relock_count: got h=%0d v=%0d want 1 0", hcount, vcount);
    end
  endtask

  task automatic test_async_reset();
    s1_t e;
    repeat (1000) begin
      tick(1'b1, 24'($urandom));
      void'(sb.pop_front());
    end
    n_cmp++;
    if (hcount !== 10'(m_h) || vcount !== 10'(m_v)) begin
      n_err++;
      $display("FAIL midframe_pos: got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, m_h, m_v);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({hcount, vcount, video_on, frame_start, vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}
        !== {10'd0, 10'd0, 1'b0, 1'b0, 24'd0, 1'b1, 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL async_reset: got h=%0d v=%0d vo=%b fs=%b rgb=%h hs=%b vs=%b bn=%b want idle",
               hcount, vcount, video_on, frame_start, {vga_r, vga_g, vga_b}, vga_hs, vga_vs, vga_blank_n);
    end
    model_reset();
    @(posedge refclk);
    #1;
    n_cmp++;
    if (hcount !== 10'd0 || frame_start !== 1'b0) begin
      n_err++;
      $display("FAIL reset_hold: got h=%0d fs=%b want 0 0", hcount, frame_start);
    end
    #2 rst = 1'b0;
    tick(1'b1, 24'($urandom));
    n_cmp++;
    if ({frame_start, hcount, vcount} !== {1'b1, 10'd0, 10'd0}) begin
      n_err++;
      $display("FAIL post_reset_start: got fs=%b h=%0d v=%0d want 1 0 0", frame_start, hcount, vcount);
    end
    for (int k = 0; k < 20; k++) begin
      e = sb.pop_front();
      n_cmp++;
      if ({vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n} !== e) begin
        n_err++;
        $display("FAIL post_reset_s1: got %h want %h", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank_n}, e);
      end
      tick(1'b1, 24'($urandom));
      n_cmp++;
      if ({hcount, vcount, video_on, frame_start} !== {10'(m_h), 10'(m_v), m_vo, m_fs}) begin
        n_err++;
        $display("FAIL post_reset_s0: got h=%0d v=%0d want h=%0d v=%0d", hcount, vcount, m_h, m_v);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_lock_start();
    test_frame();
    test_hsync();
    test_rgb();
    test_unlock();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
